// File: rtl/alu_exec.sv
// alu_exec: request sequencer, register file and architectural flag owner for the alu datapath.
// Build macro ADC_CARRY_EN: when defined, ADC folds the registered carry in through an extra INC pass.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_exec_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_INC = 4'd6,
        OP_DEC = 4'd7,
        OP_SHR = 4'd8,
        OP_SHL = 4'd9,
        OP_CMP = 4'd10
    } opcode_t;
endpackage

module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int  WORD_SIZE = `WORD_SIZE,
    parameter int  REG_COUNT = 8,
    localparam int RW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  opcode_t              req_opcode,
    input  logic [RW-1:0]        req_rx,
    input  logic [RW-1:0]        req_ry,
    input  logic                 ld_en,
    input  logic [RW-1:0]        ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    output opcode_t              alu_opcode,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_c,
    input  logic                 alu_z,
    input  logic                 alu_n,
    output logic                 done_valid,
    output logic [WORD_SIZE-1:0] done_result,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_n,
    input  logic [RW-1:0]        dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    opcode_t              op_r;
    logic [RW-1:0]        rx_r;
    logic [RW-1:0]        ry_r;
    logic [WORD_SIZE-1:0] res_r;
    logic                 c_r;
    logic                 z_r;
    logic                 n_r;
    logic [WORD_SIZE-1:0] regs [REG_COUNT];
    logic                 adc_ext_s;
    logic                 ld_we_s;
    logic                 wb_we_s;

    function automatic logic op_known(input opcode_t op);
        logic known;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_CMP: known = 1'b1;
            default:                                known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic op_writes_reg(input opcode_t op);
        return op_known(op) && (op != OP_CMP);
    endfunction

`ifdef ADC_CARRY_EN
    assign adc_ext_s = (op_r == OP_ADC) && flag_c;
`else
    assign adc_ext_s = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE);
    assign ld_we_s   = (state == ST_IDLE) && ld_en;
    assign wb_we_s   = (state == ST_WB) && op_writes_reg(op_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (adc_ext_s) begin
                    state_nxt = ST_EXEC2;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_EXEC2: state_nxt = ST_WB;
            ST_WB:    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, ALU drive/capture, write-back, flags and debug read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r        <= OP_ADD;
            rx_r        <= '0;
            ry_r        <= '0;
            res_r       <= '0;
            c_r         <= 1'b0;
            z_r         <= 1'b0;
            n_r         <= 1'b0;
            alu_opcode  <= OP_ADD;
            alu_a       <= '0;
            alu_b       <= '0;
            done_valid  <= 1'b0;
            done_result <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            dbg_data    <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done_valid <= 1'b0;
            if (ld_we_s) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_we_s) begin
                regs[rx_r] <= res_r;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r <= req_opcode;
                        rx_r <= req_rx;
                        ry_r <= req_ry;
                    end
                end
                ST_READ: begin
                    // ADC is always issued as a plain ADD; any carry-in is added by EXEC2.
                    alu_a      <= regs[rx_r];
                    alu_b      <= regs[ry_r];
                    alu_opcode <= (op_r == OP_ADC) ? OP_ADD : op_r;
                end
                ST_EXEC: begin
                    res_r <= alu_out;
                    c_r   <= alu_c;
                    z_r   <= alu_z;
                    n_r   <= alu_n;
                    if (adc_ext_s) begin
                        alu_a      <= alu_out;
                        alu_opcode <= OP_INC;
                    end else begin
                        done_valid  <= 1'b1;
                        done_result <= op_known(op_r) ? alu_out : '0;
                    end
                end
                ST_EXEC2: begin
                    res_r       <= alu_out;
                    c_r         <= c_r | (res_r == '1);
                    z_r         <= alu_z;
                    n_r         <= alu_n;
                    done_valid  <= 1'b1;
                    done_result <= alu_out;
                end
                ST_WB: begin
                    if (op_known(op_r)) begin
                        flag_c <= c_r;
                        flag_z <= z_r;
                        flag_n <= n_r;
                    end
                end
                default: begin
                end
            endcase
            if (wb_we_s && (rx_r == dbg_addr)) begin
                dbg_data <= res_r;
            end else if (ld_we_s && (ld_addr == dbg_addr)) begin
                dbg_data <= ld_data;
            end else begin
                dbg_data <= regs[dbg_addr];
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed table-driven bench for alu_exec with a behavioural ALU attached to its datapath port.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int W  = 8;
    localparam int RC = 8;
    localparam int NV = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    opcode_t      req_opcode;
    logic [2:0]   req_rx;
    logic [2:0]   req_ry;
    logic         ld_en;
    logic [2:0]   ld_addr;
    logic [W-1:0] ld_data;
    opcode_t      alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         alu_c;
    logic         alu_z;
    logic         alu_n;
    logic         done_valid;
    logic [W-1:0] done_result;
    logic         flag_c;
    logic         flag_z;
    logic         flag_n;
    logic [2:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec #(.WORD_SIZE(W), .REG_COUNT(RC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_rx(req_rx), .req_ry(req_ry),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
        .done_valid(done_valid), .done_result(done_result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: C is carry-out for add/inc, borrow for sub/dec/cmp; CMP yields 1 on equality.
    always_comb begin
        alu_out = '0;
        alu_c   = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_ADC: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: begin alu_out = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            OP_AND: alu_out = alu_a & alu_b;
            OP_OR:  alu_out = alu_a | alu_b;
            OP_XOR: alu_out = alu_a ^ alu_b;
            OP_INC: {alu_c, alu_out} = {1'b0, alu_a} + 9'd1;
            OP_DEC: begin alu_out = alu_a - 8'd1; alu_c = (alu_a == 8'd0); end
            OP_SHR: alu_out = alu_a >> alu_b;
            OP_SHL: alu_out = alu_a << alu_b;
            OP_CMP: begin alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00; alu_c = (alu_a < alu_b); end
            default: begin alu_out = '0; alu_c = 1'b0; end
        endcase
        alu_z = (alu_out == '0);
        alu_n = alu_out[W-1];
    end

    typedef struct {
        opcode_t      op;
        logic [2:0]   rx;
        logic [2:0]   ry;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [2:0]   czn;
        logic         wr;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request at a negedge; returns at the negedge after done_valid, dbg_addr pointing at rx.
    task automatic do_op(input opcode_t op, input logic [2:0] rx, input logic [2:0] ry, input bit hold,
                         input bit ld, input logic [2:0] la, input logic [W-1:0] ld_d,
                         output int lat, output logic [W-1:0] res, output int pulses);
        bit seen;
        seen = 1'b0;
        lat = 0;
        pulses = 0;
        res = '0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_rx     = rx;
        req_ry     = ry;
        ld_en      = ld;
        ld_addr    = la;
        ld_data    = ld_d;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
            @(negedge clk);
            ld_en = 1'b0;
            if (!hold) req_valid = 1'b0;
            if (done_valid) begin
                seen = 1'b1;
                lat = cyc;
                res = done_result;
                pulses++;
                req_valid = 1'b0;
                dbg_addr = rx;
            end else if (hold) begin
                check("busy_ready", 32'(req_ready), 32'd0);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        if (done_valid) pulses++;
    endtask

    int           lat;
    int           pulses;
    logic [W-1:0] res;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_ADD, 3'd1, 3'd2, 8'h0F, 8'h01, 8'h10, 3'b000, 1'b1};
        vecs[1]  = '{OP_ADD, 3'd2, 3'd3, 8'hF0, 8'h20, 8'h10, 3'b100, 1'b1};
        vecs[2]  = '{OP_SUB, 3'd1, 3'd2, 8'h00, 8'h01, 8'hFF, 3'b101, 1'b1};
        vecs[3]  = '{OP_SUB, 3'd4, 3'd0, 8'h05, 8'h05, 8'h00, 3'b010, 1'b1};
        vecs[4]  = '{OP_AND, 3'd5, 3'd6, 8'hF0, 8'h3C, 8'h30, 3'b000, 1'b1};
        vecs[5]  = '{OP_OR,  3'd7, 3'd1, 8'h80, 8'h01, 8'h81, 3'b001, 1'b1};
        vecs[6]  = '{OP_XOR, 3'd0, 3'd7, 8'hAA, 8'hAA, 8'h00, 3'b010, 1'b1};
        vecs[7]  = '{OP_INC, 3'd3, 3'd4, 8'hFF, 8'h12, 8'h00, 3'b110, 1'b1};
        vecs[8]  = '{OP_DEC, 3'd6, 3'd5, 8'h00, 8'h34, 8'hFF, 3'b101, 1'b1};
        vecs[9]  = '{OP_SHR, 3'd2, 3'd1, 8'h80, 8'h03, 8'h10, 3'b000, 1'b1};
        vecs[10] = '{OP_SHL, 3'd1, 3'd2, 8'h81, 8'h01, 8'h02, 3'b000, 1'b1};
        vecs[11] = '{OP_SHL, 3'd5, 3'd3, 8'h01, 8'h09, 8'h00, 3'b010, 1'b1};
        vecs[12] = '{OP_CMP, 3'd3, 3'd4, 8'h55, 8'h55, 8'h01, 3'b000, 1'b0};
        vecs[13] = '{OP_ADC, 3'd6, 3'd7, 8'h10, 8'h22, 8'h32, 3'b000, 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_opcode = OP_ADD; req_rx = '0; req_ry = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_result", 32'(done_result), 32'd0);
        check("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
        check("rst_aluop", 32'(alu_opcode), 32'(OP_ADD));
        check("rst_alua", 32'(alu_a), 32'd0);
        for (int i = 0; i < RC; i++) begin
            dbg_addr = 3'(i);
            @(negedge clk);
            check($sformatf("rst_r%0d", i), 32'(dbg_data), 32'd0);
        end

        for (int i = 0; i < NV; i++) begin
            load(vecs[i].rx, vecs[i].a);
            load(vecs[i].ry, vecs[i].b);
            do_op(vecs[i].op, vecs[i].rx, vecs[i].ry, 1'b0, 1'b0, 3'd0, 8'h00, lat, res, pulses);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
            check($sformatf("v%0d_reg", i), 32'(dbg_data), 32'(vecs[i].wr ? vecs[i].res : vecs[i].a));
            check($sformatf("v%0d_flags", i), 32'({flag_c, flag_z, flag_n}), 32'(vecs[i].czn));
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
        end

        // SUB leaves C=1, then ADC 0xFF + 0x00 consumes it when the carry extension is built in.
        load(3'd1, 8'h00);
        load(3'd2, 8'h01);
        do_op(OP_SUB, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00, lat, res, pulses);
        check("sub_result", 32'(res), 32'hFF);
        check("sub_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
        load(3'd2, 8'h00);
        do_op(OP_ADC, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00, lat, res, pulses);
`ifdef ADC_CARRY_EN
        check("adc_lat", 32'(lat), 32'd4);
        check("adc_result", 32'(res), 32'h00);
        check("adc_reg", 32'(dbg_data), 32'h00);
        check("adc_flags", 32'({flag_c, flag_z, flag_n}), 32'b110);
        check("adc_aluop", 32'(alu_opcode), 32'(OP_INC));
`else
        check("adc_lat", 32'(lat), 32'd3);
        check("adc_result", 32'(res), 32'hFF);
        check("adc_reg", 32'(dbg_data), 32'hFF);
        check("adc_flags", 32'({flag_c, flag_z, flag_n}), 32'b001);
        check("adc_aluop", 32'(alu_opcode), 32'(OP_ADD));
`endif
        check("adc_pulses", 32'(pulses), 32'd1);

        // CMP with req_valid held until completion: one pulse, no register write.
        load(3'd3, 8'h55);
        load(3'd4, 8'h55);
        do_op(OP_CMP, 3'd3, 3'd4, 1'b1, 1'b0, 3'd0, 8'h00, lat, res, pulses);
        check("cmp_pulses", 32'(pulses), 32'd1);
        check("cmp_result", 32'(res), 32'h01);
        check("cmp_reg", 32'(dbg_data), 32'h55);
        check("cmp_flags", 32'({flag_c, flag_z, flag_n}), 32'b000);

        // Load and request accepted in the same cycle.
        do_op(OP_INC, 3'd5, 3'd0, 1'b0, 1'b1, 3'd5, 8'hAA, lat, res, pulses);
        check("ldinc_lat", 32'(lat), 32'd3);
        check("ldinc_result", 32'(res), 32'hAB);
        check("ldinc_reg", 32'(dbg_data), 32'hAB);
        check("ldinc_flags", 32'({flag_c, flag_z, flag_n}), 32'b001);

        // Unknown opcode: result 0, no write, flags untouched.
        do_op(opcode_t'(4'hF), 3'd5, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, lat, res, pulses);
        check("unk_lat", 32'(lat), 32'd3);
        check("unk_result", 32'(res), 32'h00);
        check("unk_reg", 32'(dbg_data), 32'hAB);
        check("unk_flags", 32'({flag_c, flag_z, flag_n}), 32'b001);

        // Reset asserted during EXEC of ADD R1,R2 aborts the operation.
        load(3'd1, 8'h0F);
        load(3'd2, 8'h01);
        req_valid = 1'b1; req_opcode = OP_ADD; req_rx = 3'd1; req_ry = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 3'd1;
        pulses = 0;
        if (done_valid) pulses++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_valid) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_reg", 32'(dbg_data), 32'h00);
        check("abort_flags", 32'({flag_c, flag_z, flag_n}), 32'b000);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_alua", 32'(alu_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Sequencing front end that drives the `alu` combinational datapath and owns the machine state it reads and writes. It accepts one operation per valid/ready handshake from the control unit, reads two operands from an internal register file, presents them to the ALU, then writes the result and the C/Z/N flags back. It supplies the registered carry that ADC needs, removing the combinational flag loop from the ALU side.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE ``: datapath width.
- `REG_COUNT`, default 8: register-file depth; index width `RW = $clog2(REG_COUNT)`.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: high only in IDLE.
- `req_opcode` in `opcode_t`: operation.
- `req_rx`, `req_ry` in RW each: destination/first operand register and second operand register.
- `ld_en` in 1: register load, honoured only in IDLE.
- `ld_addr` in RW, `ld_data` in WORD_SIZE: load target and value.
- `alu_opcode` out `opcode_t`; `alu_a`, `alu_b` out WORD_SIZE: ALU inputs.
- `alu_out` in WORD_SIZE; `alu_c`, `alu_z`, `alu_n` in 1: ALU results.
- `done_valid` out 1: one-cycle completion pulse.
- `done_result` out WORD_SIZE: final result, valid with `done_valid`.
- `flag_c`, `flag_z`, `flag_n` out 1: architectural flags, registered.
- `dbg_addr` in RW, `dbg_data` out WORD_SIZE: registered register-file read.

## Operation
- FSM states: IDLE, READ, EXEC, EXEC2, WB.
- IDLE: on `req_valid && req_ready`, latch opcode, rx and ry, then go to READ.
- READ: latch `A = R[rx]`, `B = R[ry]`, then go to EXEC.
- EXEC: drive `alu_opcode` = latched opcode, `alu_a` = A, `alu_b` = B. Capture `alu_out`, `alu_c`, `alu_z` and `alu_n` into the result registers.
  - Go to EXEC2 if the opcode is ADC and `flag_c` = 1, as long as `ADC_CARRY_EN` is defined.
  - Otherwise go to WB.
- ADC handling in EXEC: drive `alu_opcode` = ADD.
- EXEC2: drive INC with `alu_a` = the captured sum.
  - Result = `alu_out`; Z and N come from the ALU.
  - C = captured C OR (captured sum == all-ones).
- WB:
  - Pulse `done_valid` and drive `done_result`.
  - Write R[rx] for ADD, ADC, SUB, AND, OR, XOR, INC, DEC, SHR and SHL.
  - CMP writes flags only.
  - All valid opcodes update all three flags.
  - Unknown opcode: no register write, flags unchanged, `done_result` = 0.
  - Return to IDLE.
- Arithmetic is modulo 2^WORD_SIZE. INC and DEC ignore B. Shift amount is the full B.
- `alu_a`, `alu_b` and `alu_opcode` hold their last driven values outside EXEC/EXEC2. They are 0 / ADD after reset.
- Load in IDLE writes R[ld_addr].
  - A load and a request accepted in the same cycle are both honoured.
  - READ sees the loaded value.
- `dbg_data` = R[dbg_addr] one cycle later, write-first: a same-cycle WB or load to that address returns the new value.

## Timing
- Reset values: all registers 0, flags 0, `done_valid` 0, `done_result` 0, `dbg_data` 0, state IDLE, `req_ready` 1 in the first cycle after reset.
- Latency, handshake at cycle 0:
  - READ in cycle 1, EXEC in cycle 2.
  - `done_valid` in cycle 3, or cycle 4 when EXEC2 runs.
  - Register and flags visible the cycle after `done_valid`; `req_ready` high again in that same cycle.
- Throughput: one operation per 4 cycles, or 5 when EXEC2 runs. `req_valid` while busy is ignored and must be held by the requester.
- Reset mid-operation: abort immediately. No write-back, no `done_valid`, all state returns to reset values.

## Configuration
- `ADC_CARRY_EN` defined: ADC adds the registered `flag_c` via EXEC2 as described under Operation.
- `ADC_CARRY_EN` undefined: ADC executes exactly as ADD. EXEC2 is never entered and latency is always 3 cycles.

## Test plan
- Reset then idle: all `dbg_data` reads 0, flags 000, `req_ready` = 1.
- Load R1 = 0x0F, R2 = 0x01, ADD rx=1 ry=2: `done_valid` at +3, `done_result` 0x10, `dbg_data`(R1) = 0x10, flags C=0 Z=0 N=0.
- With WORD_SIZE = 8: SUB R1 = 0x00 minus R2 = 0x01 gives 0xFF with C=1, N=1. A following ADC with R1 = 0xFF, R2 = 0x00 and `ADC_CARRY_EN` gives 0x00, C=1, Z=1, `done_valid` at +4.
- CMP R3 = 0x55, R4 = 0x55: R3 unchanged, flags updated from ALU output 0x01 (Z=0). `req_valid` held high throughout gives exactly one `done_valid`.
- Same-cycle load R5 = 0xAA and request INC rx=5 ry=0: result 0xAB, and `dbg_data`(R5) shows 0xAB in the cycle after WB.
- `rst_n` low during EXEC of `ADD R1,R2`: no `done_valid`, R1 = 0, flags 000, `req_ready` high after reset.
